// File: rtl/key_debounce_sched_if.sv
`default_nettype none
// ============================================================================
// key_debounce_sched_if : raw key pins in, debounced key events/levels out
// Rev 1.0
// ============================================================================
interface key_debounce_sched_if #(
    parameter int KEY_NUM = 4
);
    logic [KEY_NUM-1:0] key_in;
    logic [KEY_NUM-1:0] key_flag;
    logic [KEY_NUM-1:0] key_rls;
    logic [KEY_NUM-1:0] key_state;
    logic               busy;
    logic [2:0]         cur_key;

    modport master (
        output key_in,
        input  key_flag, key_rls, key_state, busy, cur_key
    );

    modport slave (
        input  key_in,
        output key_flag, key_rls, key_state, busy, cur_key
    );
endinterface
`default_nettype wire

// File: rtl/key_debounce_sched.sv
`default_nettype none
// ============================================================================
// key_debounce_sched : one shared debounce counter serving KEY_NUM keys in RR
// Rev 1.0
// ============================================================================
module key_debounce_sched #(
    parameter int          KEY_NUM = 4,
    parameter logic [19:0] CNT_MAX = 20'd999_999
) (
    input  wire logic           sys_clk,
    input  wire logic           sys_rst,
    key_debounce_sched_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_QUALIFY = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    localparam logic [2:0]         c_LAST     = 3'(KEY_NUM - 1);
    localparam logic [19:0]        c_CNT_LAST = CNT_MAX - 20'd1;
    localparam logic [KEY_NUM-1:0] c_ONE      = {{(KEY_NUM-1){1'b0}}, 1'b1};

    state_t             r_state, w_state_nxt;
    logic [KEY_NUM-1:0] r_sync1, r_sync2;
    logic [KEY_NUM-1:0] r_key_state, w_key_state_nxt;
    logic [KEY_NUM-1:0] r_flag, w_flag_nxt;
    logic [KEY_NUM-1:0] r_rls, w_rls_nxt;
    logic [19:0]        r_cnt, w_cnt_nxt;
    logic [2:0]         r_rr_ptr, w_rr_nxt;
    logic [2:0]         r_sel, w_sel_nxt;
    logic [2:0]         r_cur_key, w_cur_nxt;
    logic               r_busy, w_busy_nxt;

    logic [KEY_NUM-1:0] w_pend;
    logic [KEY_NUM-1:0] w_sel_mask;
    logic [KEY_NUM-1:0] w_cand;
    logic [3:0]         w_idx;
    logic               w_hit;
    logic [2:0]         w_hit_idx;
    logic [2:0]         w_sel_inc;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= bus.key_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pend     = r_sync2 ^ r_key_state;
    assign w_sel_mask = c_ONE << r_sel;
    assign w_sel_inc  = (r_sel == c_LAST) ? 3'd0 : r_sel + 3'd1;

    // First pending key at or after rr_ptr, wrapping at KEY_NUM.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = 3'd0;
        w_idx     = 4'd0;
        w_cand    = '0;
        for (int k = 0; k < KEY_NUM; k++) begin
            w_idx = {1'b0, r_rr_ptr} + 4'(k);
            if (w_idx >= 4'(KEY_NUM)) begin
                w_idx = w_idx - 4'(KEY_NUM);
            end
            w_cand = w_pend & (c_ONE << w_idx);
            if (!w_hit && (|w_cand)) begin
                w_hit     = 1'b1;
                w_hit_idx = w_idx[2:0];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_sel_nxt       = r_sel;
        w_rr_nxt        = r_rr_ptr;
        w_cur_nxt       = r_cur_key;
        w_busy_nxt      = r_busy;
        w_key_state_nxt = r_key_state;
        w_flag_nxt      = '0;
        w_rls_nxt       = '0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_sel_nxt   = w_hit_idx;
                    w_cur_nxt   = w_hit_idx;
                    w_cnt_nxt   = 20'd0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_QUALIFY;
                end
            end
            S_QUALIFY: begin
                if (!(|(w_pend & w_sel_mask))) begin
                    w_cnt_nxt   = 20'd0;
                    w_busy_nxt  = 1'b0;
                    w_rr_nxt    = w_sel_inc;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_COMMIT;
                end else begin
                    w_cnt_nxt = r_cnt + 20'd1;
                end
            end
            S_COMMIT: begin
                w_key_state_nxt = r_key_state ^ w_sel_mask;
                // Old level 1 (released) means the key has just been pressed.
                if (|(r_key_state & w_sel_mask)) begin
                    w_flag_nxt = w_sel_mask;
                end else begin
                    w_rls_nxt = w_sel_mask;
                end
                w_busy_nxt  = 1'b0;
                w_rr_nxt    = w_sel_inc;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 20'd0;
            r_sel       <= 3'd0;
            r_rr_ptr    <= 3'd0;
            r_cur_key   <= 3'd0;
            r_busy      <= 1'b0;
            r_key_state <= '1;
            r_flag      <= '0;
            r_rls       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sel       <= w_sel_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_cur_key   <= w_cur_nxt;
            r_busy      <= w_busy_nxt;
            r_key_state <= w_key_state_nxt;
            r_flag      <= w_flag_nxt;
            r_rls       <= w_rls_nxt;
        end
    end

    assign bus.key_flag  = r_flag;
    assign bus.key_rls   = r_rls;
    assign bus.key_state = r_key_state;
    assign bus.busy      = r_busy;
    assign bus.cur_key   = r_cur_key;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_sched.sv
`default_nettype none
// ============================================================================
// tb_key_debounce_sched : bench for key_debounce_sched (KEY_NUM=4, CNT_MAX=24)
// Rev 1.0
// ============================================================================
module tb_key_debounce_sched;

    localparam int K  = 4;
    localparam int CM = 24;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    key_debounce_sched_if #(.KEY_NUM(K)) kif();

    key_debounce_sched #(
        .KEY_NUM (K),
        .CNT_MAX (20'd24)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (kif)
    );

    always #10 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    always @(posedge sys_clk) edge_n <= edge_n + 1;

    // Event log sampled on the falling edge, tagged with the rising edge index.
    typedef struct {
        int key;
        int at;
        bit rls;
        int cur;
    } ev_t;
    ev_t ev_q[$];
    int  busy_cnt  = 0;
    int  multi_cnt = 0;

    always @(negedge sys_clk) begin
        if (kif.busy === 1'b1) busy_cnt++;
        if ($countones(kif.key_flag | kif.key_rls) > 1) multi_cnt++;
        for (int k = 0; k < K; k++) begin
            if (kif.key_flag[k] === 1'b1) ev_q.push_back('{k, edge_n, 1'b0, int'(kif.cur_key)});
            if (kif.key_rls[k] === 1'b1)  ev_q.push_back('{k, edge_n, 1'b1, int'(kif.cur_key)});
        end
    end

    // Reference model: keys seen two edges late, served one at a time with an
    // elapsed-edge timer; a stable run of CM edges leads to a commit edge.
    logic [K-1:0] m_h1 = '1, m_h2 = '1, m_st = '1, m_flag = '0, m_rls = '0;
    logic         m_busy = 1'b0;
    int           m_phase = 0, m_owner = 0, m_rr = 0, m_start = 0, m_cur = 0, m_n = 0;

    always @(posedge sys_clk) begin : model
        logic [K-1:0] v;
        bit           found;
        int           i;
        v      = m_h2;
        m_h2   = m_h1;
        m_h1   = kif.key_in;
        m_n    = m_n + 1;
        m_flag = '0;
        m_rls  = '0;
        if (sys_rst) begin
            m_h1 = '1; m_h2 = '1; m_st = '1;
            m_phase = 0; m_rr = 0; m_cur = 0; m_busy = 1'b0;
        end else if (m_phase == 0) begin
            found = 1'b0;
            for (int k = 0; k < K; k++) begin
                i = (m_rr + k) % K;
                if (!found && v[i] != m_st[i]) begin
                    found = 1'b1; m_owner = i; m_cur = i;
                    m_start = m_n; m_busy = 1'b1; m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (v[m_owner] == m_st[m_owner]) begin
                m_phase = 0; m_busy = 1'b0; m_rr = (m_owner + 1) % K;
            end else if (m_n - m_start == CM) begin
                m_phase = 2;
            end
        end else begin
            m_st[m_owner] = ~m_st[m_owner];
            if (m_st[m_owner] == 1'b0) m_flag[m_owner] = 1'b1;
            else                       m_rls[m_owner]  = 1'b1;
            m_busy = 1'b0; m_rr = (m_owner + 1) % K; m_phase = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    function automatic int count_ev(input int from, input int key, input bit rls);
        int n = 0;
        for (int j = from; j < ev_q.size(); j++)
            if ((key < 0 || ev_q[j].key == key) && ev_q[j].rls == rls) n++;
        return n;
    endfunction

    typedef struct {
        logic [3:0] keys;
        int         hold;
        logic [3:0] st;
        int         flags;
        int         rls;
    } vec_t;

    initial begin
        vec_t       tbl[6];
        int         e0, s0, b0, m0, rel, lat, rate;
        int         exp_key[3];
        logic [3:0] keys;
        logic [15:0] dv, mv;

        tbl[0] = '{4'b1111,  40, 4'b1111, 0, 0};
        tbl[1] = '{4'b1110,  60, 4'b1110, 1, 0};
        tbl[2] = '{4'b1010, 100, 4'b1010, 1, 0};
        tbl[3] = '{4'b1011,  60, 4'b1011, 0, 1};
        tbl[4] = '{4'b0100, 150, 4'b0100, 3, 1};
        tbl[5] = '{4'b1111, 150, 4'b1111, 0, 3};

        kif.key_in = '1;
        sys_rst    = 1'b1;
        settle(3);
        @(negedge sys_clk);
        chk("rst_key_state", kif.key_state, 4'hF);
        chk("rst_key_flag",  kif.key_flag,  0);
        chk("rst_key_rls",   kif.key_rls,   0);
        chk("rst_busy",      kif.busy,      0);
        chk("rst_cur_key",   kif.cur_key,   0);
        tick();
        sys_rst = 1'b0;

        // Table-driven level sequences
        m0 = multi_cnt;
        for (int v = 0; v < 6; v++) begin
            s0 = ev_q.size();
            kif.key_in = tbl[v].keys;
            settle(tbl[v].hold);
            @(negedge sys_clk);
            chk($sformatf("tbl%0d_state", v), kif.key_state, tbl[v].st);
            chk($sformatf("tbl%0d_flags", v), count_ev(s0, -1, 1'b0), tbl[v].flags);
            chk($sformatf("tbl%0d_rls",   v), count_ev(s0, -1, 1'b1), tbl[v].rls);
        end
        chk("tbl_onehot", multi_cnt - m0, 0);

        // Clean press of key 0
        tick();
        s0 = ev_q.size(); b0 = busy_cnt;
        kif.key_in[0] = 1'b0;
        e0 = edge_n + 1;
        settle(100);
        @(negedge sys_clk);
        chk("t1_events", ev_q.size() - s0, 1);
        if (ev_q.size() > s0) begin
            chk("t1_kind",    ev_q[s0].rls, 0);
            chk("t1_key",     ev_q[s0].key, 0);
            chk("t1_latency", ev_q[s0].at - e0, CM + 3);
        end
        chk("t1_busy_len", busy_cnt - b0, CM + 1);
        chk("t1_state",    kif.key_state, 4'b1110);

        // Release of key 0
        tick();
        s0 = ev_q.size();
        kif.key_in[0] = 1'b1;
        e0 = edge_n + 1;
        settle(60);
        @(negedge sys_clk);
        chk("t3_rls",   count_ev(s0, 0, 1'b1), 1);
        chk("t3_flags", count_ev(s0, -1, 1'b0), 0);
        if (ev_q.size() > s0) chk("t3_latency", ev_q[s0].at - e0, CM + 3);
        chk("t3_state", kif.key_state, 4'b1111);

        // Bouncing key 1, then a stable press
        tick();
        s0 = ev_q.size();
        for (int c = 0; c < 30; c++) begin
            kif.key_in[1] = (c == 29) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
        end
        kif.key_in[1] = 1'b0;
        e0 = edge_n + 1;
        settle(60);
        @(negedge sys_clk);
        chk("t2_events", ev_q.size() - s0, 1);
        if (ev_q.size() > s0) begin
            chk("t2_key",     ev_q[s0].key, 1);
            chk("t2_kind",    ev_q[s0].rls, 0);
            chk("t2_latency", ev_q[s0].at - e0, CM + 3);
        end
        chk("t2_state", kif.key_state, 4'b1101);
        kif.key_in[1] = 1'b1;
        settle(60);

        // Simultaneous press of keys 0, 2, 3 from rr_ptr = 0
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        s0 = ev_q.size();
        kif.key_in = 4'b0010;
        e0 = edge_n + 1;
        exp_key = '{0, 2, 3};
        settle(150);
        @(negedge sys_clk);
        chk("t4_events", ev_q.size() - s0, 3);
        for (int j = 0; j < 3; j++) begin
            if (ev_q.size() > s0 + j) begin
                chk($sformatf("t4_key%0d", j),  ev_q[s0+j].key, exp_key[j]);
                chk($sformatf("t4_cur%0d", j),  ev_q[s0+j].cur, exp_key[j]);
                chk($sformatf("t4_edge%0d", j), ev_q[s0+j].at - e0, CM + 3 + j * (CM + 2));
            end
        end
        kif.key_in = 4'b1111;
        settle(150);

        // Fairness: key 1 chatters while key 2 is pressed
        tick();
        s0 = ev_q.size();
        kif.key_in[2] = 1'b0;
        e0 = edge_n + 1;
        for (int c = 0; c < 100; c++) begin
            if (c % 2 == 0) kif.key_in[1] = ~kif.key_in[1];
            tick();
        end
        kif.key_in[1] = 1'b1;
        settle(40);
        @(negedge sys_clk);
        lat = -1;
        for (int j = s0; j < ev_q.size(); j++)
            if (lat < 0 && ev_q[j].key == 2 && !ev_q[j].rls) lat = ev_q[j].at - e0;
        chk("t5_key2_flags", count_ev(s0, 2, 1'b0), 1);
        chk("t5_key1_flags", count_ev(s0, 1, 1'b0), 0);
        chk("t5_key1_rls",   count_ev(s0, 1, 1'b1), 0);
        chk("t5_bound", (lat >= 0 && lat <= 2 * (CM + 2) + 3), 1);
        kif.key_in[2] = 1'b1;
        settle(60);

        // Reset while key 3 is mid-qualification (cnt = 10)
        tick();
        s0 = ev_q.size();
        kif.key_in[3] = 1'b0;
        e0 = edge_n + 1;
        while (edge_n < e0 + 12) tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        rel = edge_n + 1;
        @(negedge sys_clk);
        chk("t6_busy",   kif.busy,      0);
        chk("t6_state",  kif.key_state, 4'hF);
        chk("t6_cur",    kif.cur_key,   0);
        chk("t6_pulses", ev_q.size() - s0, 0);
        settle(60);
        @(negedge sys_clk);
        chk("t6_events", ev_q.size() - s0, 1);
        if (ev_q.size() > s0) begin
            chk("t6_key",     ev_q[s0].key, 3);
            chk("t6_latency", ev_q[s0].at - rel, CM + 3);
        end
        kif.key_in[3] = 1'b1;
        settle(60);

        // Randomized traffic against the reference model
        rate = 60;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) rate = ($urandom_range(0, 2) == 0) ? 4 : 60;
            keys = kif.key_in;
            for (int k = 0; k < K; k++)
                if ($urandom_range(0, rate - 1) == 0) keys[k] = ~keys[k];
            kif.key_in = keys;
            sys_rst = ($urandom_range(0, 599) == 0);
            tick();
            @(negedge sys_clk);
            dv = {kif.key_flag, kif.key_rls, kif.key_state, kif.busy, kif.cur_key};
            mv = {m_flag, m_rls, m_st, m_busy, 3'(m_cur)};
            chk($sformatf("model_cyc%0d", c), dv, mv);
        end
        sys_rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
